// File: rtl/rf_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never busy.
module rf_mp_sb #(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  output logic [AW:0]         busy_cnt
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busyCnt;

  logic [NREG-1:0] w_busyNext;
  logic [AW:0]     w_busyCntNext;
  logic [AW-1:0]   w_rdAddr;
  logic            w_hit;

  // Clear on writeback first, then a same-cycle set overrides it.
  always_comb begin
    w_busyNext = r_busy;
    for (int r = 1; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == AW'(r))) begin
          w_busyNext[r] = 1'b0;
        end
      end
      if (set_en && (set_addr == AW'(r))) begin
        w_busyNext[r] = 1'b1;
      end
    end
    w_busyNext[0] = 1'b0;
  end

  always_comb begin
    w_busyCntNext = '0;
    for (int r = 0; r < NREG; r++) begin
      w_busyCntNext = w_busyCntNext + (AW+1)'(w_busyNext[r]);
    end
  end

  // Later write ports are visited last, so the highest-index writer wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_rf[r] <= '0;
      end
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (waddr[j*AW +: AW] == AW'(r))) begin
            r_rf[r] <= wdata[j*XLEN +: XLEN];
          end
        end
      end
      r_busy    <= w_busyNext;
      r_busyCnt <= w_busyCntNext;
    end
  end

  // Bypass is suppressed during reset so reads stay zero while it is held.
  always_comb begin
    rdata    = '0;
    rbusy    = '0;
    w_rdAddr = '0;
    w_hit    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      w_rdAddr = raddr[i*AW +: AW];
      w_hit    = 1'b0;
      rdata[i*XLEN +: XLEN] = r_rf[w_rdAddr];
      if ((BYPASS != 0) && !reset && (w_rdAddr != '0)) begin
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (waddr[j*AW +: AW] == w_rdAddr)) begin
            w_hit = 1'b1;
            rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          end
        end
      end
      rbusy[i] = r_busy[w_rdAddr] && !w_hit && (w_rdAddr != '0);
    end
  end

  assign busy_cnt = r_busyCnt;

endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed bench for rf_mp_sb: one bypassing and one non-bypassing instance
// share the same stimulus and are compared against hand-computed vectors.
module tb_rf_mp_sb;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clock;
  logic            reset;
  logic [2*AW-1:0] raddr;
  logic [1:0]      wen;
  logic [2*AW-1:0] waddr;
  logic [2*XLEN-1:0] wdata;
  logic            set_en;
  logic [AW-1:0]   set_addr;

  logic [2*XLEN-1:0] rdataB, rdataN;
  logic [1:0]        rbusyB, rbusyN;
  logic [AW:0]       cntB, cntN;

  int checks = 0;
  int errors = 0;

  rf_mp_sb #(.XLEN(XLEN), .AW(AW), .NRD(2), .NWR(2), .BYPASS(1)) u_dutB (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdataB), .rbusy(rbusyB),
    .wen(wen), .waddr(waddr), .wdata(wdata), .set_en(set_en), .set_addr(set_addr),
    .busy_cnt(cntB)
  );

  rf_mp_sb #(.XLEN(XLEN), .AW(AW), .NRD(2), .NWR(2), .BYPASS(0)) u_dutN (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdataN), .rbusy(rbusyN),
    .wen(wen), .waddr(waddr), .wdata(wdata), .set_en(set_en), .set_addr(set_addr),
    .busy_cnt(cntN)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0]      wen;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            setEn;
    logic [AW-1:0]   setA;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] eB0, eB1;
    logic [1:0]      eBusyB;
    logic [XLEN-1:0] eN0, eN1;
    logic [1:0]      eBusyN;
    logic [AW:0]     eCnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] DEAD = 64'hDEADBEEF_00000001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wen      = v.wen;
    waddr    = {v.wa1, v.wa0};
    wdata    = {v.wd1, v.wd0};
    set_en   = v.setEn;
    set_addr = v.setA;
    raddr    = {v.ra1, v.ra0};
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; set_en = 1'b0; set_addr = '0;
  endtask

  initial begin
    // wen wa0 wa1 wd0 wd1 set setA ra0 ra1 | eB0 eB1 eBusyB | eN0 eN1 eBusyN | eCnt
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd3, 64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00, 6'd0});
    vecs.push_back('{2'b01, 5'd5, 5'd0, DEAD, 64'h0, 1'b0, 5'd0, 5'd5, 5'd0, DEAD, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd5, DEAD, DEAD, 2'b00, DEAD, DEAD, 2'b00, 6'd0});
    vecs.push_back('{2'b11, 5'd0, 5'd0, ONES, ONES, 1'b1, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd5, 64'h0, DEAD, 2'b00, 64'h0, DEAD, 2'b00, 6'd0});
    vecs.push_back('{2'b11, 5'd7, 5'd7, 64'h11, 64'h22, 1'b0, 5'd0, 5'd7, 5'd7, 64'h22, 64'h22, 2'b00, 64'h0, 64'h0, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd5, 64'h22, DEAD, 2'b00, 64'h22, DEAD, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd10, 5'd10, 5'd7, 64'h0, 64'h22, 2'b00, 64'h0, 64'h22, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd10, 5'd3, 64'h0, 64'h0, 2'b01, 64'h0, 64'h0, 2'b01, 6'd1});
    vecs.push_back('{2'b01, 5'd10, 5'd0, 64'hA5, 64'h0, 1'b0, 5'd0, 5'd10, 5'd10, 64'hA5, 64'hA5, 2'b00, 64'h0, 64'h0, 2'b11, 6'd1});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd10, 5'd0, 64'hA5, 64'h0, 2'b00, 64'hA5, 64'h0, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd12, 5'd12, 5'd12, 64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00, 6'd0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd12, 5'd10, 64'h0, 64'hA5, 2'b01, 64'h0, 64'hA5, 2'b01, 6'd1});
    vecs.push_back('{2'b10, 5'd0, 5'd12, 64'h0, 64'h1234, 1'b1, 5'd12, 5'd12, 5'd12, 64'h1234, 64'h1234, 2'b00, 64'h0, 64'h0, 2'b11, 6'd1});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd12, 5'd12, 64'h1234, 64'h1234, 2'b11, 64'h1234, 64'h1234, 2'b11, 6'd1});
    vecs.push_back('{2'b01, 5'd12, 5'd0, 64'h55, 64'h0, 1'b1, 5'd3, 5'd12, 5'd3, 64'h55, 64'h0, 2'b00, 64'h1234, 64'h0, 2'b01, 6'd1});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd12, 5'd3, 64'h55, 64'h0, 2'b10, 64'h55, 64'h0, 2'b10, 6'd1});

    reset = 1'b1;
    idle();
    raddr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("v%0d rdataB0", k), rdataB[63:0],   vecs[k].eB0);
      checkOutput($sformatf("v%0d rdataB1", k), rdataB[127:64], vecs[k].eB1);
      checkOutput($sformatf("v%0d rbusyB",  k), 64'(rbusyB),    64'(vecs[k].eBusyB));
      checkOutput($sformatf("v%0d rdataN0", k), rdataN[63:0],   vecs[k].eN0);
      checkOutput($sformatf("v%0d rdataN1", k), rdataN[127:64], vecs[k].eN1);
      checkOutput($sformatf("v%0d rbusyN",  k), 64'(rbusyN),    64'(vecs[k].eBusyN));
      checkOutput($sformatf("v%0d cntB",    k), 64'(cntB),      64'(vecs[k].eCnt));
      checkOutput($sformatf("v%0d cntN",    k), 64'(cntN),      64'(vecs[k].eCnt));
      @(negedge clock);
    end

    // Asynchronous reset mid-cycle: x5 holds data and x3 is busy beforehand.
    idle();
    raddr = {5'd3, 5'd5};
    #1;
    checkOutput("pre-reset x5", rdataB[63:0], DEAD);
    checkOutput("pre-reset rbusy", 64'(rbusyB), 64'(2'b10));
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset rdataB", rdataB, 128'h0);
    checkOutput("async reset rdataN", rdataN, 128'h0);
    checkOutput("async reset rbusyB", 64'(rbusyB), 64'h0);
    checkOutput("async reset rbusyN", 64'(rbusyN), 64'h0);
    checkOutput("async reset cntB", 64'(cntB), 64'h0);
    checkOutput("async reset cntN", 64'(cntN), 64'h0);

    // Writes and sets presented while reset is held must be discarded.
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'h0, 64'h99};
    set_en = 1'b1; set_addr = 5'd9;
    raddr = {5'd9, 5'd5};
    #1;
    checkOutput("reset bypass blocked", rdataB[63:0], 64'h0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    #1;
    checkOutput("discarded write x5 B", rdataB[63:0], 64'h0);
    checkOutput("discarded write x5 N", rdataN[63:0], 64'h0);
    checkOutput("discarded set x9 B", 64'(rbusyB), 64'h0);
    checkOutput("discarded set cnt", 64'(cntB), 64'h0);
    @(negedge clock);
    #1;
    checkOutput("post-reset cnt", 64'(cntN), 64'h0);
    checkOutput("post-reset rbusyN", 64'(rbusyN), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
